// File: rtl/lsu_bus_master.sv
// Multi-cycle load/store unit: MEM stage to req/gnt + rvalid data bus; optional LSU_TIMEOUT_EN bus timeout.
// Latency: op -> lsu_done in 2 cycles minimum (1 cycle for misaligned/access faults), more with slow slaves.
// Backpressure: stalls the pipeline while busy; holds bus_req and its outputs until bus_gnt.
module lsu_bus_master #(
    parameter int XLEN        = 32,
    parameter int NUM_SEL     = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         mem_op,
    input  logic [XLEN-1:0]    cpu_addr,
    input  logic [XLEN-1:0]    cpu_wdata,
    output logic [XLEN-1:0]    cpu_rdata,
    output logic               lsu_stall,
    output logic               lsu_done,
    output logic               fault_misalign,
    output logic               fault_access,
`ifdef LSU_TIMEOUT_EN
    output logic               fault_timeout,
`endif
    output logic               bus_req,
    output logic               bus_we,
    output logic [XLEN-1:0]    bus_addr,
    output logic [XLEN-1:0]    bus_wdata,
    output logic [3:0]         bus_mask,
    output logic [NUM_SEL-1:0] bus_sel,
    input  logic               bus_gnt,
    input  logic               bus_rvalid,
    input  logic [XLEN-1:0]    bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    localparam logic [4:0] OP_LB  = 5'h01;
    localparam logic [4:0] OP_LH  = 5'h02;
    localparam logic [4:0] OP_LW  = 5'h03;
    localparam logic [4:0] OP_LBU = 5'h04;
    localparam logic [4:0] OP_LHU = 5'h05;
    localparam logic [4:0] OP_SB  = 5'h16;
    localparam logic [4:0] OP_SH  = 5'h17;
    localparam logic [4:0] OP_SW  = 5'h18;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t             state_q, state_d;
    logic               we_q, we_d, uns_q, uns_d, mis_q, mis_d, acc_q, acc_d;
    logic [1:0]         sz_q, sz_d, off_q, off_d;
    logic [3:0]         mask_q, mask_d;
    logic [XLEN-1:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_SEL-1:0] sel_q, sel_d;

    logic               op_vld, op_we, op_uns, op_mis, op_acc;
    logic [1:0]         op_sz;
    logic [3:0]         op_mask, region;
    logic [XLEN-1:0]    op_wdata;
    logic [NUM_SEL-1:0] op_sel;

    always_comb begin
        op_vld = 1'b1;
        op_we  = 1'b0;
        op_uns = 1'b0;
        op_sz  = SZ_W;
        case (mem_op)
            OP_LB:   op_sz = SZ_B;
            OP_LH:   op_sz = SZ_H;
            OP_LW:   op_sz = SZ_W;
            OP_LBU:  begin op_sz = SZ_B; op_uns = 1'b1; end
            OP_LHU:  begin op_sz = SZ_H; op_uns = 1'b1; end
            OP_SB:   begin op_sz = SZ_B; op_we  = 1'b1; end
            OP_SH:   begin op_sz = SZ_H; op_we  = 1'b1; end
            OP_SW:   begin op_sz = SZ_W; op_we  = 1'b1; end
            default: op_vld = 1'b0;  // OFF and unused encodings start nothing
        endcase

        op_mis = (op_sz == SZ_H && cpu_addr[0]) || (op_sz == SZ_W && cpu_addr[1:0] != 2'b00);
        region = cpu_addr[XLEN-1 -: 4];
        op_acc = !op_mis && (int'(region) >= NUM_SEL);
        for (int i = 0; i < NUM_SEL; i++) begin
            op_sel[i] = (int'(region) == i);
        end

        op_mask  = 4'b1111;
        op_wdata = cpu_wdata;
        if (op_we) begin
            case (op_sz)
                SZ_B: begin
                    op_mask  = 4'b0001 << cpu_addr[1:0];
                    op_wdata = {4{cpu_wdata[7:0]}};
                end
                SZ_H: begin
                    op_mask  = cpu_addr[1] ? 4'b1100 : 4'b0011;
                    op_wdata = {2{cpu_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [XLEN-1:0] ld_fmt;

    always_comb begin
        ld_b = bus_rdata[{off_q, 3'b000} +: 8];
        ld_h = bus_rdata[{off_q[1], 4'b0000} +: 16];
        case (sz_q)
            SZ_B:    ld_fmt = {{24{ld_b[7] & ~uns_q}}, ld_b};
            SZ_H:    ld_fmt = {{16{ld_h[15] & ~uns_q}}, ld_h};
            default: ld_fmt = bus_rdata;
        endcase
    end

    // Transaction completes on the bus: store granted, or load data returned
    logic bus_ok;
    assign bus_ok = (state_q == REQ && bus_gnt && (we_q || bus_rvalid)) ||
                    (state_q == RSP && bus_rvalid);

    logic tmo_hit, tmo_flag;
`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign tmo_hit  = (cnt_q >= CW'(TIMEOUT_CYC - 1));
    assign tmo_flag = tmo_q;
    assign fault_timeout = lsu_done & tmo_q;

    always_comb begin
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (state_q == IDLE && op_vld) begin
            cnt_d = '0;
            tmo_d = 1'b0;
        end else if (state_q == REQ || state_q == RSP) begin
            cnt_d = cnt_q + CW'(1);
            if (tmo_hit && !bus_ok) tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign tmo_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        acc_d   = acc_q;
        sz_d    = sz_q;
        off_d   = off_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: if (op_vld) begin
                we_d    = op_we;
                uns_d   = op_uns;
                sz_d    = op_sz;
                off_d   = cpu_addr[1:0];
                mis_d   = op_mis;
                acc_d   = op_acc;
                addr_d  = {cpu_addr[XLEN-1:2], 2'b00};
                wdata_d = op_wdata;
                mask_d  = op_mask;
                sel_d   = op_sel;
                state_d = (op_mis || op_acc) ? DONE : REQ;
            end
            REQ: begin
                if (bus_ok) begin
                    if (!we_q) rdata_d = ld_fmt;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end else if (bus_gnt) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (bus_ok) begin
                    rdata_d = ld_fmt;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            mis_q   <= 1'b0;
            acc_q   <= 1'b0;
            sz_q    <= SZ_B;
            off_q   <= 2'b00;
            mask_q  <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            mis_q   <= mis_d;
            acc_q   <= acc_d;
            sz_q    <= sz_d;
            off_q   <= off_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            sel_q   <= sel_d;
        end
    end

    assign bus_req        = (state_q == REQ);
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign bus_mask       = mask_q;
    assign bus_sel        = sel_q;
    assign lsu_stall      = (state_q == REQ) || (state_q == RSP) || (state_q == IDLE && op_vld);
    assign lsu_done       = (state_q == DONE);
    assign fault_misalign = lsu_done & mis_q;
    assign fault_access   = lsu_done & acc_q;
    // Last load result is held except while a store or faulted op reports done
    assign cpu_rdata      = (lsu_done && (we_q || mis_q || acc_q || tmo_flag)) ? '0 : rdata_q;

endmodule
